// File: rtl/io_input_conditioner.sv
// Board input conditioner: per-channel 2-flop synchronizer and counter debouncer.
// Buttons also produce press/release pulses and clearable sticky press flags.
module io_input_conditioner #(
  parameter int BTN_COUNT       = 2,
  parameter int SW_COUNT        = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_COUNT-1:0] btn_raw,
  input  logic [SW_COUNT-1:0]  sw_raw,
  input  logic [BTN_COUNT-1:0] clr_press,
  output logic [BTN_COUNT-1:0] btns,
  output logic [SW_COUNT-1:0]  switches,
  output logic [BTN_COUNT-1:0] btn_press,
  output logic [BTN_COUNT-1:0] btn_release,
  output logic [BTN_COUNT-1:0] btn_sticky
);

  localparam int N  = BTN_COUNT + SW_COUNT;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [BTN_COUNT-1:0] btn_in;
  logic [N-1:0]         s1_d, s1_q, s2_d, s2_q;
  logic [N-1:0]         level_d, level_q;
  logic [CW-1:0]        cnt_d [N];
  logic [CW-1:0]        cnt_q [N];
  logic [BTN_COUNT-1:0] press_d, press_q;
  logic [BTN_COUNT-1:0] release_d, release_q;
  logic [BTN_COUNT-1:0] sticky_d, sticky_q;

  // Buttons and switches share one channel vector, buttons in the low bits.
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_comb begin
    s1_d = {sw_raw, btn_in};
    s2_d = s1_q;
  end

  // The counter is zero whenever s2 agrees with the accepted level, so it
  // doubles as the STABLE/COUNTING state: any agreeing edge restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    press_d   = level_d[BTN_COUNT-1:0] & ~level_q[BTN_COUNT-1:0];
    release_d = ~level_d[BTN_COUNT-1:0] & level_q[BTN_COUNT-1:0];
    // A press on the same edge as a clear keeps the flag set.
    sticky_d  = press_d | (sticky_q & ~clr_press);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      sticky_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      sticky_q  <= sticky_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btns        = level_q[BTN_COUNT-1:0];
  assign switches    = level_q[N-1:BTN_COUNT];
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_sticky  = sticky_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: table vectors, hand-written corner sequences and
// random stimulus checked every cycle against a sliding-window reference model.
module tb_io_input_conditioner;

  localparam int B = 2;
  localparam int S = 10;
  localparam int D = 4;
  localparam int N = B + S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [B-1:0] btn_raw;
  logic [S-1:0] sw_raw;
  logic [B-1:0] clr_press;
  logic [B-1:0] btns;
  logic [S-1:0] switches;
  logic [B-1:0] btn_press;
  logic [B-1:0] btn_release;
  logic [B-1:0] btn_sticky;

  io_input_conditioner #(
    .BTN_COUNT(B), .SW_COUNT(S), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .clr_press(clr_press), .btns(btns), .switches(switches),
    .btn_press(btn_press), .btn_release(btn_release), .btn_sticky(btn_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: a channel flips once the last D synchronized samples all
  // disagree with its current level; samples reach the debouncer two edges late.
  logic [N-1:0] p1, p2, m_level;
  logic [N-1:0] win[$];
  logic [B-1:0] m_press, m_release, m_sticky;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({btns, switches, btn_press, btn_release, btn_sticky});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({m_level[B-1:0], m_level[N-1:B], m_press, m_release, m_sticky});
  endfunction

  task automatic model_reset();
    p1 = '0; p2 = '0; m_level = '0;
    win.delete();
    m_press = '0; m_release = '0; m_sticky = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] seen, old;
    seen = p2;
    p2 = p1;
    p1 = {sw_raw, ~btn_raw};
    win.push_back(seen);
    if (win.size() > D) void'(win.pop_front());
    old = m_level;
    for (int c = 0; c < N; c++) begin
      bit flip;
      flip = (win.size() == D);
      foreach (win[k]) if (win[k][c] == old[c]) flip = 1'b0;
      if (flip) m_level[c] = ~old[c];
    end
    m_press   = m_level[B-1:0] & ~old[B-1:0];
    m_release = ~m_level[B-1:0] & old[B-1:0];
    m_sticky  = m_press | (m_sticky & ~clr_press);
  endtask

  // One clock edge with the currently driven inputs, then model comparison.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", dut_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [B-1:0] btn;
    logic [B-1:0] exp_btns;
    logic [B-1:0] exp_press;
    logic [B-1:0] exp_sticky;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt_p, cnt_r, t_p, t_r;

    for (int i = 0; i < 8; i++) begin
      tbl[i].btn        = 2'b10;
      tbl[i].exp_btns   = (i >= 5) ? 2'b01 : 2'b00;
      tbl[i].exp_press  = (i == 5) ? 2'b01 : 2'b00;
      tbl[i].exp_sticky = (i >= 5) ? 2'b01 : 2'b00;
    end

    rst_n = 1'b0; btn_raw = 2'b11; sw_raw = '0; clr_press = '0;
    model_reset();
    #12;
    do_reset();

    // Idle after reset with buttons released: nothing moves.
    for (int i = 0; i < 20; i++) step();
    chk("idle_quiet", dut_vec(), 32'd0);
    $display("idle 20 cycles: btns=%b sticky=%b", btns, btn_sticky);

    // Button 0 press, expected values per cycle from the table.
    for (int i = 0; i < 8; i++) begin
      btn_raw = tbl[i].btn;
      step();
      chk("tbl_btns", 32'(btns), 32'(tbl[i].exp_btns));
      chk("tbl_press", 32'(btn_press), 32'(tbl[i].exp_press));
      chk("tbl_sticky", 32'(btn_sticky), 32'(tbl[i].exp_sticky));
      $display("vec %0d: btn_raw=%b btns=%b press=%b sticky=%b", i, btn_raw, btns, btn_press, btn_sticky);
    end

    // 3-cycle glitch on button 1 is rejected.
    cnt_p = 0;
    for (int i = 0; i < 13; i++) begin
      btn_raw = (i < 3) ? 2'b00 : 2'b10;
      step();
      if (btn_press[1]) cnt_p++;
    end
    chk("glitch3_press", 32'(cnt_p), 32'd0);
    chk("glitch3_sticky", 32'(btn_sticky[1]), 32'd0);
    $display("glitch 3 cycles: presses=%0d sticky1=%b", cnt_p, btn_sticky[1]);

    // 4-cycle pulse on button 1 is accepted: press then release.
    cnt_p = 0; cnt_r = 0; t_p = -1; t_r = -1;
    for (int i = 0; i < 16; i++) begin
      btn_raw = (i < 4) ? 2'b00 : 2'b10;
      step();
      if (btn_press[1]) begin cnt_p++; t_p = i; end
      if (btn_release[1]) begin cnt_r++; t_r = i; end
    end
    chk("pulse4_press_cnt", 32'(cnt_p), 32'd1);
    chk("pulse4_release_cnt", 32'(cnt_r), 32'd1);
    chk("pulse4_press_time", 32'(t_p), 32'd5);
    chk("pulse4_release_time", 32'(t_r), 32'd9);
    $display("pulse 4 cycles: press@%0d release@%0d", t_p, t_r);

    // Release button 0, then bounce it: low 2, high 1, low held.
    btn_raw = 2'b11;
    for (int i = 0; i < 8; i++) step();
    cnt_p = 0; t_p = -1;
    for (int i = 0; i < 14; i++) begin
      btn_raw = (i == 2) ? 2'b11 : 2'b10;
      step();
      if (btn_press[0]) begin cnt_p++; t_p = i; end
    end
    chk("bounce_press_cnt", 32'(cnt_p), 32'd1);
    chk("bounce_press_time", 32'(t_p), 32'd8);
    $display("bounce: presses=%0d at step %0d", cnt_p, t_p);

    // Clear alone drops the flag on the next edge.
    clr_press = 2'b01;
    step();
    chk("clr_alone", 32'(btn_sticky[0]), 32'd0);
    clr_press = 2'b00;
    btn_raw = 2'b11;
    for (int i = 0; i < 8; i++) step();
    // Press coinciding with clear: set wins.
    for (int i = 0; i < 6; i++) begin
      btn_raw = 2'b10;
      clr_press = (i == 5) ? 2'b01 : 2'b00;
      step();
    end
    chk("clr_set_press", 32'(btn_press[0]), 32'd1);
    chk("clr_set_sticky", 32'(btn_sticky[0]), 32'd1);
    clr_press = 2'b01;
    step();
    chk("clr_after_set", 32'(btn_sticky[0]), 32'd0);
    clr_press = 2'b00;
    $display("sticky clear/set: sticky0=%b", btn_sticky[0]);

    // Switches high through reset release.
    btn_raw = 2'b11;
    sw_raw = 10'h3FF;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("sw_startup", 32'(switches), (i == 6) ? 32'h3FF : 32'h0);
    end
    $display("switch startup: switches=%h after 6 edges", switches);

    // Reset in the middle of a debounce count.
    sw_raw = 10'h000;
    btn_raw = 2'b10;
    step(); step();
    do_reset();
    sw_raw = 10'h000;
    btn_raw = 2'b11;
    for (int i = 0; i < 8; i++) step();
    chk("midcount_reset", dut_vec(), 32'd0);
    $display("mid-count reset: outputs=%h", dut_vec());

    // Random stimulus with long-ish holds so many transitions are accepted.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if ($urandom_range(0, 4) == 0) btn_raw[$urandom_range(0, B-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) sw_raw[$urandom_range(0, S-1)] ^= 1'b1;
      clr_press = ($urandom_range(0, 5) == 0) ? B'($urandom) : '0;
      step();
    end
    $display("random: 400 cycles done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
